// File: rtl/alu_accum.sv
// alu_accum: single-stage ALU with an accumulator, sticky overflow flag and a
// one-entry output register behind a valid/ready handshake.
//
// Handshake: a transfer happens on any cycle where valid and ready are both 1.
// The producer holds valid and its payload until that cycle. The consumer may
// change ready at any time. On the input side, in_ready is purely
// combinational from the output register state, so an operation can be
// accepted in the same cycle the previous result is drained.
module alu_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic             accept;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;

  // The output register is either empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // ACC reuses the adder with the accumulator standing in for operand B.
  assign add_b    = (op == OP_ACC) ? acc : b;
  assign sum_ext  = {1'b0, a} + {1'b0, add_b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Select result and carry/borrow for the requested operation, with optional
  // saturation toward all-ones (add overflow) or zero (subtract borrow).
  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    case (op)
      OP_ADD, OP_ACC: begin
        next_carry  = sum_ext[WIDTH];
        next_result = (sat && sum_ext[WIDTH]) ? '1 : sum_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        next_carry  = diff_ext[WIDTH];
        next_result = (sat && diff_ext[WIDTH]) ? '0 : diff_ext[WIDTH-1:0];
      end
      OP_LOAD: begin
        next_carry  = 1'b0;
        next_result = a;
      end
      default: begin
        next_carry  = 1'b0;
        next_result = '0;
      end
    endcase
  end

  // Output register, accumulator and sticky overflow. Reset discards any
  // in-flight result; accept takes priority over a plain drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= next_result;
      carry     <= next_carry;
      if (op == OP_ACC || op == OP_LOAD) begin
        acc <= next_result;
      end
      // LOAD never carries, so clearing here cannot race a set.
      if (op == OP_LOAD) begin
        ovf <= 1'b0;
      end else if (next_carry) begin
        ovf <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_accum.sv
// Directed testbench for alu_accum (WIDTH=8). Inputs are driven on the
// falling edge and outputs are sampled on the following falling edge.
module tb_alu_accum;

  localparam int W  = 8;
  localparam int EW = W + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic         sat;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic [W-1:0] acc;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  alu_accum #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sat       (sat),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .acc       (acc)
  );

  // Driver: apply inputs at a falling edge, advance to the next falling edge.
  task automatic drive(input logic v, input logic [1:0] o, input logic s,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ordy);
    in_valid  = v;
    op        = o;
    sat       = s;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = OP_ADD; sat = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {out_valid, carry, ovf, result, acc}, 19'd0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    drive(1'b1, OP_ADD, 1'b0, 8'd200, 8'd100, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b1, 1'b1, 8'd44, 8'd0}) begin
      errors++;
      $display("FAIL add_wrap: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b1, 1'b1, 8'd44, 8'd0});
    end
    drive(1'b1, OP_ADD, 1'b1, 8'd200, 8'd100, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b1, 1'b1, 8'd255, 8'd0}) begin
      errors++;
      $display("FAIL add_sat: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b1, 1'b1, 8'd255, 8'd0});
    end
  endtask

  task automatic test_acc();
    drive(1'b1, OP_LOAD, 1'b0, 8'd250, 8'd17, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b0, 1'b0, 8'd250, 8'd250}) begin
      errors++;
      $display("FAIL acc_load250: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b0, 1'b0, 8'd250, 8'd250});
    end
    drive(1'b1, OP_ACC, 1'b0, 8'd3, 8'd99, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b0, 1'b0, 8'd253, 8'd253}) begin
      errors++;
      $display("FAIL acc_add3: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b0, 1'b0, 8'd253, 8'd253});
    end
    drive(1'b1, OP_ACC, 1'b0, 8'd10, 8'd0, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b1, 1'b1, 8'd7, 8'd7}) begin
      errors++;
      $display("FAIL acc_wrap: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b1, 1'b1, 8'd7, 8'd7});
    end
    drive(1'b1, OP_LOAD, 1'b0, 8'd0, 8'd0, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL acc_load0_clear: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    end
  endtask

  task automatic test_sub();
    drive(1'b1, OP_LOAD, 1'b0, 8'd77, 8'd0, 1'b1);
    drive(1'b1, OP_SUB, 1'b0, 8'd5, 8'd9, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b1, 1'b1, 8'd252, 8'd77}) begin
      errors++;
      $display("FAIL sub_wrap: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b1, 1'b1, 8'd252, 8'd77});
    end
    drive(1'b1, OP_SUB, 1'b1, 8'd5, 8'd9, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b1, 1'b1, 8'd0, 8'd77}) begin
      errors++;
      $display("FAIL sub_sat: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b1, 1'b1, 8'd0, 8'd77});
    end
    drive(1'b1, OP_SUB, 1'b0, 8'd9, 8'd5, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b0, 1'b1, 8'd4, 8'd77}) begin
      errors++;
      $display("FAIL sub_noborrow: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b0, 1'b1, 8'd4, 8'd77});
    end
  endtask

  task automatic test_stall();
    drive(1'b1, OP_LOAD, 1'b0, 8'd5, 8'd0, 1'b1);
    drive(1'b0, OP_ADD, 1'b0, 8'd0, 8'd0, 1'b1);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_drain: got %b expected 01", {out_valid, in_ready});
    end
    drive(1'b1, OP_ADD, 1'b0, 8'd10, 8'd20, 1'b0);
    checks++;
    if ({in_ready, out_valid, carry, ovf, result, acc} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd30, 8'd5}) begin
      errors++;
      $display("FAIL stall_accept: got %h expected %h", {in_ready, out_valid, carry, ovf, result, acc}, {1'b0, 1'b1, 1'b0, 1'b0, 8'd30, 8'd5});
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_LOAD, 1'b1, 8'(99 + i), 8'(i), 1'b0);
      checks++;
      if ({in_ready, out_valid, carry, ovf, result, acc} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd30, 8'd5}) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h expected %h", i, {in_ready, out_valid, carry, ovf, result, acc}, {1'b0, 1'b1, 1'b0, 1'b0, 8'd30, 8'd5});
      end
    end
    in_valid = 1'b1; op = OP_ADD; sat = 1'b0; a = 8'd1; b = 8'd2; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b0, 1'b0, 8'd3, 8'd5}) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b0, 1'b0, 8'd3, 8'd5});
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] expv;
    logic [W-1:0]  av;
    int            ready_low;
    drive(1'b0, OP_ADD, 1'b0, 8'd0, 8'd0, 1'b1);
    ready_low = 0;
    for (int i = 0; i < 16; i++) begin
      av = 8'(i * 17);
      in_valid = 1'b1; op = OP_ADD; sat = 1'b0; a = av; b = 8'd120; out_ready = 1'b1;
      exp_q.push_back({1'b0, av} + 9'd120);
      #1;
      if (in_ready !== 1'b1) ready_low++;
      @(posedge clk);
      @(negedge clk);
      expv = exp_q.pop_front();
      checks++;
      if ({out_valid, carry, result} !== {1'b1, expv}) begin
        errors++;
        $display("FAIL b2b_%0d: got %h expected %h", i, {out_valid, carry, result}, {1'b1, expv});
      end
    end
    checks++;
    if (ready_low != 0) begin
      errors++;
      $display("FAIL b2b_in_ready: got %0d cycles low expected 0", ready_low);
    end
    drive(1'b0, OP_ADD, 1'b0, 8'd0, 8'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_flush();
    drive(1'b1, OP_LOAD, 1'b0, 8'd40, 8'd0, 1'b1);
    drive(1'b1, OP_ACC, 1'b0, 8'd250, 8'd0, 1'b1);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== {1'b1, 1'b1, 1'b1, 8'd34, 8'd34}) begin
      errors++;
      $display("FAIL flush_setup: got %h expected %h", {out_valid, carry, ovf, result, acc}, {1'b1, 1'b1, 1'b1, 8'd34, 8'd34});
    end
    rst = 1'b1;
    drive(1'b1, OP_ACC, 1'b0, 8'd1, 8'd1, 1'b0);
    checks++;
    if ({out_valid, carry, ovf, result, acc} !== 19'd0) begin
      errors++;
      $display("FAIL flush_reset: got %h expected %h", {out_valid, carry, ovf, result, acc}, 19'd0);
    end
    rst = 1'b0;
    drive(1'b0, OP_ADD, 1'b0, 8'd0, 8'd0, 1'b0);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_in_ready: got %b expected 10", {in_ready, out_valid});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_acc();
    test_sub();
    test_stall();
    test_back_to_back();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_accum.md
ALU_ACCUM -- requirements
Module: alu_accum

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 op  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-007 sat  input  1  1 = saturating arithmetic for this operation, 0 = wrapping.
REQ-008 a  input  WIDTH  operand A, unsigned.
REQ-009 b  input  WIDTH  operand B, unsigned; ignored for ACC and LOAD.
REQ-010 out_valid  output  1  result register holds an undelivered result.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 carry  output  1  registered carry/borrow of the delivered operation.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 acc  output  WIDTH  current accumulator value.

Function
REQ-016 Accept occurs on a cycle with in_valid=1 and in_ready=1; drain occurs on a cycle with out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL be combinationally (!out_valid || out_ready); no other path to in_ready.
REQ-018 On accept, result/carry SHALL be registered and out_valid SHALL be 1 the next cycle (latency 1).
REQ-019 On drain without accept, out_valid SHALL go 0 next cycle; on simultaneous drain and accept, out_valid SHALL stay 1 with the new result.
REQ-020 While out_valid=1 and out_ready=0, result, carry and out_valid SHALL hold stable and no operation SHALL be accepted.
REQ-021 ADD: (WIDTH+1)-bit sum a+b; carry = sum MSB; result = low WIDTH bits, or all-ones if sat=1 and carry=1.
REQ-022 SUB: a-b modulo 2^WIDTH; carry = borrow (1 iff a<b); if sat=1 and borrow, result = 0.
REQ-023 ACC: acc+a computed as ADD with acc as operand B; result and new acc = that (possibly saturated) value; carry as ADD.
REQ-024 LOAD: acc and result SHALL take a; carry = 0; ovf SHALL clear.
REQ-025 acc SHALL change only on accept of ACC or LOAD; ADD and SUB SHALL leave acc unchanged.
REQ-026 ovf SHALL set on accept of any ADD, SUB or ACC producing carry=1, regardless of sat, and stay set until LOAD or reset.
REQ-027 Accept of LOAD SHALL clear ovf even if a simultaneous-cycle condition would otherwise set it (LOAD never carries).
REQ-028 acc output SHALL reflect the updated value on the cycle after accept, same cycle result becomes valid.
REQ-029 Inputs op, sat, a, b SHALL be sampled only on accept; changes at other times SHALL have no effect.
REQ-030 Accumulator wrap (sat=0) SHALL be modulo 2^WIDTH with no other side effect besides carry/ovf.
REQ-031 Sustained in_valid=1 and out_ready=1 SHALL yield one accepted operation per cycle with no bubbles.

Reset
REQ-032 While rst=1 at a clock edge: out_valid=0, result=0, carry=0, ovf=0, acc=0.
REQ-033 rst SHALL take priority over accept and drain in the same cycle; any in-flight result SHALL be discarded.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts (out_valid=0).

Verification (WIDTH=8)
REQ-035 Reset, then ADD a=200 b=100 sat=0 -> next cycle out_valid=1, result=44, carry=1, ovf=1; same with sat=1 -> result=255, carry=1.
REQ-036 SUB a=5 b=9 sat=0 -> result=252, carry=1; sat=1 -> result=0, carry=1; SUB a=9 b=5 -> result=4, carry=0, acc unchanged.
REQ-037 LOAD a=250, then ACC a=3, ACC a=10 (sat=0), out_ready=1 every cycle -> results 250, 253, 7 on consecutive cycles, last carry=1, ovf=1, acc=7; then LOAD a=0 -> ovf=0.
REQ-038 ADD accepted with out_ready=0 for 3 cycles while in_valid=1 and a/b change -> in_ready=0, result held for 3 cycles; out_ready=1 -> drain and next accept in same cycle, out_valid stays 1.
REQ-039 Back-to-back 16 ADDs with out_ready=1 -> 16 results on 16 consecutive cycles, in_ready constantly 1.
REQ-040 rst=1 asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, acc=0, ovf=0, result=0; following cycle in_ready=1.
